// File: rtl/imem_arb_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
package imem_arb_pkg;

    localparam int unsigned IMEM_BLOCK_SIZE = 8;
    localparam int unsigned LEN_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_e;

    // Limit a requested burst length (minus one) to what a refill block holds.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Arbitrates a single-port combinational instruction memory between a
// cache-refill burst port and a single-word data read port.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BLOCK_SIZE = IMEM_BLOCK_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c_req,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [3:0]            c_len,
    output logic                  c_ready,
    output logic                  c_valid,
    output logic [DATA_WIDTH-1:0] c_data,
    output logic                  c_last,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam int unsigned MAX_LEN = (BLOCK_SIZE > 16) ? 15 :
                                      ((BLOCK_SIZE == 0) ? 0 : BLOCK_SIZE - 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    arb_state_e            state_q, state_d;
    logic                  c_pri_q, c_pri_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      count_q, count_d;
    logic                  c_valid_q, c_valid_d;
    logic                  c_last_q, c_last_d;
    logic [DATA_WIDTH-1:0] c_data_q, c_data_d;
    logic                  d_valid_q, d_valid_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic                  grant_c, grant_d;
    logic                  issue_c, issue_last;
    logic [ADDR_WIDTH-1:0] c_base, d_base;
    logic [LEN_W-1:0]      c_len_clamp;

    assign c_base      = c_addr & ~(ADDR_WIDTH'(2'b11));
    assign d_base      = d_addr & ~(ADDR_WIDTH'(2'b11));
    assign c_len_clamp = clamp_len(c_len, MAX_LEN_L);

    // State register; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            c_pri_q   <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            count_q   <= '0;
            c_valid_q <= 1'b0;
            c_last_q  <= 1'b0;
            c_data_q  <= '0;
            d_valid_q <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            c_pri_q   <= c_pri_d;
            base_q    <= base_d;
            len_q     <= len_d;
            count_q   <= count_d;
            c_valid_q <= c_valid_d;
            c_last_q  <= c_last_d;
            c_data_q  <= c_data_d;
            d_valid_q <= d_valid_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Grant decision and memory address for the current cycle.
    always_comb begin
        grant_c    = 1'b0;
        grant_d    = 1'b0;
        issue_c    = 1'b0;
        issue_last = 1'b0;
        mem_addr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (rst) begin
                    if (c_req && (!d_req || c_pri_q)) begin
                        grant_c = 1'b1;
                    end else if (d_req) begin
                        grant_d = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                issue_c    = 1'b1;
                issue_last = (count_q == len_q);
                mem_addr   = base_q + ADDR_WIDTH'({count_q, 2'b00});
            end
            default: ;
        endcase
        if (grant_c) begin
            issue_c    = 1'b1;
            issue_last = (c_len_clamp == '0);
            mem_addr   = c_base;
        end
        if (grant_d) begin
            mem_addr = d_base;
        end
    end

    // Next state; read data is captured the cycle its address is issued.
    always_comb begin
        state_d   = state_q;
        c_pri_d   = c_pri_q;
        base_d    = base_q;
        len_d     = len_q;
        count_d   = count_q;
        c_valid_d = issue_c;
        c_last_d  = issue_last;
        c_data_d  = issue_c ? mem_rdata : c_data_q;
        d_valid_d = grant_d;
        d_rdata_d = grant_d ? mem_rdata : d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    base_d  = c_base;
                    len_d   = c_len_clamp;
                    count_d = LEN_W'(1);
                    c_pri_d = 1'b0;
                    state_d = (c_len_clamp == '0) ? ST_IDLE : ST_BURST;
                end else if (grant_d) begin
                    c_pri_d = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_BURST: begin
                if (issue_last) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q + LEN_W'(1);
                end
            end
            ST_DATA:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign c_ready = grant_c;
    assign d_gnt   = grant_d;
    assign c_valid = c_valid_q;
    assign c_last  = c_last_q;
    assign c_data  = c_data_q;
    assign d_valid = d_valid_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a combinational memory model.
module tb_imem_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req;
    logic [31:0] c_addr;
    logic [3:0]  c_len;
    logic        c_ready, c_valid, c_last;
    logic [31:0] c_data;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_gnt, d_valid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'd7) ^ 32'hC0DE_F00D;
    endfunction

    assign mem_rdata = word_at(mem_addr);

    imem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .c_req     (c_req),
        .c_addr    (c_addr),
        .c_len     (c_len),
        .c_ready   (c_ready),
        .c_valid   (c_valid),
        .c_data    (c_data),
        .c_last    (c_last),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_gnt     (d_gnt),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a refill from IDLE and follow it word by word; ends on the IDLE cycle
    // carrying the final c_valid. Optionally raises a data request mid-burst.
    task automatic run_burst(input logic [31:0] addr, input logic [3:0] len,
                             input int n, input bit with_d);
        logic [31:0] base;
        base   = addr & ~32'h3;
        c_req  = 1'b1;
        c_addr = addr;
        c_len  = len;
        @(negedge clk);
        chk("c_ready", 32'(c_ready), 32'd1);
        chk("burst_a0", mem_addr, base);
        for (int k = 1; k <= n; k++) begin
            step();
            if (k == 1) begin
                c_req = 1'b0;
                if (with_d) begin
                    d_req  = 1'b1;
                    d_addr = 32'h204;
                end
            end
            @(negedge clk);
            chk("c_valid", 32'(c_valid), 32'd1);
            chk("c_data", c_data, word_at(base + 32'(4 * (k - 1))));
            chk("c_last", 32'(c_last), 32'(k == n));
            if (k < n) begin
                chk("burst_addr", mem_addr, base + 32'(4 * k));
                chk("busy", 32'(busy), 32'd1);
                if (with_d) chk("d_gnt_blocked", 32'(d_gnt), 32'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst    = 1'b0;
        c_req  = 1'b1;
        c_addr = 32'h40;
        c_len  = 4'd0;
        d_req  = 1'b1;
        d_addr = 32'h207;
        #3;
        chk("rst_c_ready", 32'(c_ready), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_c_valid", 32'(c_valid), 32'd0);
        chk("rst_c_last", 32'(c_last), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_c_data", c_data, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        step();
        step();

        // Both requests right after reset: data port first, then refill.
        rst = 1'b1;
        @(negedge clk);
        chk("first_d_gnt", 32'(d_gnt), 32'd1);
        chk("first_c_ready", 32'(c_ready), 32'd0);
        chk("first_d_addr", mem_addr, 32'h204);
        step();
        d_req = 1'b0;
        @(negedge clk);
        chk("first_d_valid", 32'(d_valid), 32'd1);
        chk("first_d_rdata", d_rdata, word_at(32'h204));
        chk("data_busy", 32'(busy), 32'd1);
        chk("data_no_c_ready", 32'(c_ready), 32'd0);
        step();
        run_burst(32'h40, 4'd0, 1, 1'b0);
        chk("len0_busy", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        chk("len0_c_valid_off", 32'(c_valid), 32'd0);
        chk("len0_d_valid_off", 32'(d_valid), 32'd0);

        // Full 8-word burst from 0x100.
        step();
        run_burst(32'h100, 4'd7, 8, 1'b0);
        step();
        @(negedge clk);
        chk("b8_c_valid_off", 32'(c_valid), 32'd0);
        chk("b8_c_data_hold", c_data, word_at(32'h11C));
        chk("b8_mem_addr_idle", mem_addr, 32'd0);

        // Data request arriving mid-burst waits for the burst to finish.
        step();
        run_burst(32'h302, 4'd3, 4, 1'b1);
        chk("late_d_gnt", 32'(d_gnt), 32'd1);
        chk("late_d_addr", mem_addr, 32'h204);
        step();
        d_req = 1'b0;
        @(negedge clk);
        chk("late_d_valid", 32'(d_valid), 32'd1);
        chk("late_d_rdata", d_rdata, word_at(32'h204));

        // Round robin: data was granted last, so refill wins the tie.
        step();
        c_req  = 1'b1;
        c_addr = 32'h80;
        c_len  = 4'd0;
        d_req  = 1'b1;
        d_addr = 32'h10;
        @(negedge clk);
        chk("rr_c_ready", 32'(c_ready), 32'd1);
        chk("rr_d_gnt_wait", 32'(d_gnt), 32'd0);
        step();
        c_req = 1'b0;
        @(negedge clk);
        chk("rr_c_valid", 32'(c_valid), 32'd1);
        chk("rr_c_last", 32'(c_last), 32'd1);
        chk("rr_d_gnt", 32'(d_gnt), 32'd1);
        chk("rr_d_addr", mem_addr, 32'h10);
        step();
        d_req = 1'b0;
        @(negedge clk);
        chk("rr_d_rdata", d_rdata, word_at(32'h10));

        // Address wrap at the top of the space.
        step();
        run_burst(32'hFFFF_FFF8, 4'd3, 4, 1'b0);

        // Oversized length is clamped to the block size.
        step();
        run_burst(32'h500, 4'd15, 8, 1'b0);
        step();
        @(negedge clk);
        chk("clamp_stop", 32'(c_valid), 32'd0);

        // Reset while the third word of a burst is on c_data.
        step();
        c_req  = 1'b1;
        c_addr = 32'h100;
        c_len  = 4'd7;
        step();
        c_req = 1'b0;
        step();
        step();
        chk("pre_rst_c_valid", 32'(c_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_c_valid", 32'(c_valid), 32'd0);
        chk("mid_rst_c_last", 32'(c_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_c_data", c_data, 32'd0);
        step();
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (c_valid || busy) seen++;
            step();
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
